// File: rtl/msg_scroller.sv
// Message buffer feeding the 4-digit LED driver: digits are appended while idle,
// then a 4-digit window scrolls circularly through the stored message.
//
// state  | meaning
// IDLE   | accepting writes, msg held (blank after reset/clear)
// SCROLL | window advances one digit every TICK_DIV clocks (len>=4)
module msg_scroller #(
   parameter int          DEPTH    = 8,
   parameter int          TICK_DIV = 4,
   parameter logic [3:0]  BLANK    = 4'hF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [3:0]                   wr_data,
   output logic                         wr_ready,
   input  logic                         clear,
   input  logic                         start,
   input  logic                         stop,
   output logic [15:0]                  msg,
   output logic [$clog2(DEPTH+1)-1:0]   len,
   output logic                         busy,
   output logic                         wrap
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int HW = $clog2(DEPTH);
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic {IDLE = 1'b0, SCROLL = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic [HW-1:0]   head_q, head_d, head_inc;
   logic [TW-1:0]   tick_q, tick_d;
   logic [15:0]     msg_q, msg_d;
   logic            wrap_q, wrap_d;
   logic [3:0]      buf_q [DEPTH];

   logic            start_go, wr_go, long_msg, step, head_last;

   // Window starting at head h; short messages are shown left-aligned, unscrolled.
   function automatic logic [15:0] window(input logic [HW-1:0] h);
      logic [15:0] w;
      logic [LW:0] idx;
      w = {4{BLANK}};
      for (int i = 0; i < 4; i++) begin
         if (len_q >= LW'(4)) begin
            idx = (LW+1)'(h) + (LW+1)'(i);
            if (idx >= (LW+1)'(len_q))
               idx = idx - (LW+1)'(len_q);
            w[15-4*i -: 4] = buf_q[idx[HW-1:0]];
         end else if (LW'(i) < len_q) begin
            w[15-4*i -: 4] = buf_q[HW'(i)];
         end
      end
      return w;
   endfunction

   assign start_go  = start & ~stop & (state_q == IDLE) & (len_q != '0);
   assign wr_go     = wr_en & wr_ready & ~clear & ~start_go;
   assign long_msg  = (len_q >= LW'(4));
   assign step      = (state_q == SCROLL) & long_msg & (tick_q == TW'(TICK_DIV-1));
   assign head_last = (LW'(head_q) == len_q - LW'(1));
   assign head_inc  = head_last ? '0 : head_q + HW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         head_q  <= '0;
         tick_q  <= '0;
         msg_q   <= {4{BLANK}};
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         head_q  <= head_d;
         tick_q  <= tick_d;
         msg_q   <= msg_d;
         wrap_q  <= wrap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_go)
         buf_q[len_q[HW-1:0]] <= wr_data;
   end

   always_comb begin
      state_d = state_q;
      if (clear)
         state_d = IDLE;
      else if (state_q == SCROLL && stop)
         state_d = IDLE;
      else if (start_go)
         state_d = SCROLL;
   end

   always_comb begin
      len_d  = len_q;
      head_d = head_q;
      tick_d = tick_q;
      msg_d  = msg_q;
      wrap_d = 1'b0;
      if (clear) begin
         len_d  = '0;
         head_d = '0;
         tick_d = '0;
         msg_d  = {4{BLANK}};
      end else if (state_q == SCROLL) begin
         if (!stop && long_msg) begin
            if (step) begin
               tick_d = '0;
               head_d = head_inc;
               msg_d  = window(head_inc);
               wrap_d = head_last;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
      end else if (start_go) begin
         head_d = '0;
         tick_d = '0;
         msg_d  = window('0);
      end else if (wr_go) begin
         len_d = len_q + LW'(1);
      end
   end

   always_comb begin
      wr_ready = (state_q == IDLE) && (len_q < LW'(DEPTH));
      busy     = (state_q == SCROLL);
   end

   assign msg  = msg_q;
   assign len  = len_q;
   assign wrap = wrap_q;

endmodule
